peak_hold_bank: RTL and testbench

//   Multi-channel successor to the single 8-bit gated data register of the VU-meter path.

---
 rtl/peak_hold_bank.sv | 143 ++++++++++++++
 tb/tb_peak_hold_bank.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/peak_hold_bank.sv
// peak_hold_bank: bank of independent peak-hold meters.
// Each channel keeps the last accepted sample and a peak value that is held
// for HOLD_CYCLES enabled cycles after capture, then decays by DECAY_STEP per
// enabled cycle (saturating at zero). Rejected loads raise a sticky error flag.
module peak_hold_bank #(
   parameter int WIDTH       = 8,
   parameter int CHANNELS    = 2,
   parameter int HOLD_CYCLES = 1024,
   parameter int DECAY_STEP  = 1
) (
   input  logic                      i_clock,
   input  logic                      i_reset,
   input  logic                      i_enable,
   input  logic                      i_clear,
   input  logic [CHANNELS-1:0]       i_load,
   input  logic [CHANNELS-1:0]       i_error,
   input  logic [CHANNELS*WIDTH-1:0] i_data_in,
   output logic [CHANNELS*WIDTH-1:0] o_data_out,
   output logic [CHANNELS*WIDTH-1:0] o_peak_out,
   output logic [CHANNELS-1:0]       o_peak_new,
   output logic [CHANNELS-1:0]       o_error_sticky
);

   localparam int TW = $clog2(HOLD_CYCLES + 1);
   localparam logic [TW-1:0]    HOLD_INIT = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0]    TIMER_ONE = TW'(1);
   localparam logic [WIDTH-1:0] DSTEP     = WIDTH'(DECAY_STEP);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HOLD  = 2'd1,
      ST_DECAY = 2'd2
   } state_t;

   genvar g;
   generate
      for (g = 0; g < CHANNELS; g++) begin : g_ch
         state_t            r_state, w_state_nxt;
         logic [TW-1:0]     r_timer, w_timer_nxt;
         logic [WIDTH-1:0]  r_peak, w_peak_nxt;
         logic [WIDTH-1:0]  r_data;
         logic [WIDTH-1:0]  w_sample;
         logic              r_peak_new, w_peak_new_nxt;
         logic              r_err;
         logic              w_accept, w_reject, w_capture;

         assign w_sample  = i_data_in[g*WIDTH +: WIDTH];
         assign w_accept  = i_enable & i_load[g] & ~i_error[g];
         assign w_reject  = i_enable & i_load[g] & i_error[g];
         // A sample equal to the current peak also captures, restarting the hold.
         assign w_capture = w_accept & (w_sample >= r_peak);

         // Next-state logic: clear > capture > hold countdown > decay.
         always_comb begin
            w_state_nxt    = r_state;
            w_timer_nxt    = r_timer;
            w_peak_nxt     = r_peak;
            w_peak_new_nxt = 1'b0;
            if (i_clear) begin
               w_state_nxt = ST_IDLE;
               w_timer_nxt = '0;
               w_peak_nxt  = '0;
            end else if (w_capture) begin
               w_state_nxt    = ST_HOLD;
               w_timer_nxt    = HOLD_INIT;
               w_peak_nxt     = w_sample;
               w_peak_new_nxt = 1'b1;
            end else if (i_enable) begin
               case (r_state)
                  ST_IDLE: begin
                     w_state_nxt = ST_IDLE;
                  end
                  ST_HOLD: begin
                     // Peak is unchanged on the cycle the hold expires.
                     if (r_timer != '0) begin
                        w_timer_nxt = r_timer - TIMER_ONE;
                     end else begin
                        w_state_nxt = ST_DECAY;
                     end
                  end
                  ST_DECAY: begin
                     // Saturating subtraction: never wraps below zero.
                     if (r_peak > DSTEP) begin
                        w_peak_nxt = r_peak - DSTEP;
                     end else begin
                        w_peak_nxt  = '0;
                        w_state_nxt = ST_IDLE;
                     end
                  end
                  default: begin
                     w_state_nxt = ST_IDLE;
                     w_timer_nxt = '0;
                     w_peak_nxt  = '0;
                  end
               endcase
            end else begin
               w_state_nxt = r_state;
            end
         end

         // Peak FSM state, hold timer, peak value and new-peak pulse registers.
         always_ff @(posedge i_clock or posedge i_reset) begin
            if (i_reset) begin
               r_state    <= ST_IDLE;
               r_timer    <= '0;
               r_peak     <= '0;
               r_peak_new <= 1'b0;
            end else begin
               r_state    <= w_state_nxt;
               r_timer    <= w_timer_nxt;
               r_peak     <= w_peak_nxt;
               r_peak_new <= w_peak_new_nxt;
            end
         end

         // Last accepted sample; clear deliberately leaves it alone.
         always_ff @(posedge i_clock or posedge i_reset) begin
            if (i_reset) begin
               r_data <= '1;
            end else if (w_accept) begin
               r_data <= w_sample;
            end
         end

         // Sticky flag for rejected loads; clear wins over a same-cycle reject.
         always_ff @(posedge i_clock or posedge i_reset) begin
            if (i_reset) begin
               r_err <= 1'b0;
            end else if (i_clear) begin
               r_err <= 1'b0;
            end else if (w_reject) begin
               r_err <= 1'b1;
            end
         end

         assign o_data_out[g*WIDTH +: WIDTH] = r_data;
         assign o_peak_out[g*WIDTH +: WIDTH] = r_peak;
         assign o_peak_new[g]                = r_peak_new;
         assign o_error_sticky[g]            = r_err;
      end
   endgenerate

endmodule

// File: tb/tb_peak_hold_bank.sv
// Self-checking bench for peak_hold_bank (WIDTH=8, CHANNELS=2, HOLD_CYCLES=4,
// DECAY_STEP=16): directed vector table, hand-written corner sequences and a
// randomized phase compared against a behavioural model.
module tb_peak_hold_bank;
   localparam int W  = 8;
   localparam int CH = 2;
   localparam int HC = 4;
   localparam int DS = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          en, clr;
   logic [1:0]    ld, er;
   logic [15:0]   din;
   logic [15:0]   dout, peak;
   logic [1:0]    pnew, errs;

   int n_vec = 0;
   int n_err = 0;

   peak_hold_bank #(.WIDTH(W), .CHANNELS(CH), .HOLD_CYCLES(HC), .DECAY_STEP(DS)) dut (
      .i_clock(clk), .i_reset(rst), .i_enable(en), .i_clear(clr),
      .i_load(ld), .i_error(er), .i_data_in(din),
      .o_data_out(dout), .o_peak_out(peak), .o_peak_new(pnew), .o_error_sticky(errs)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // Peak is held for HC enabled cycles after a capture, then loses DS per
   // enabled cycle, floored at zero.
   int m_data [CH];
   int m_peak [CH];
   int m_hold [CH];
   bit m_pn   [CH];
   bit m_err  [CH];

   function automatic void model_reset();
      for (int c = 0; c < CH; c++) begin
         m_data[c] = 255; m_peak[c] = 0; m_hold[c] = 0; m_pn[c] = 0; m_err[c] = 0;
      end
   endfunction

   function automatic void model_step();
      for (int c = 0; c < CH; c++) begin
         int s;
         bit acc, rej;
         s   = int'(din[c*W +: W]);
         acc = en && ld[c] && !er[c];
         rej = en && ld[c] && er[c];
         if (acc) m_data[c] = s;
         if (clr) m_err[c] = 0;
         else if (rej) m_err[c] = 1;
         m_pn[c] = 0;
         if (clr) begin
            m_peak[c] = 0; m_hold[c] = 0;
         end else if (acc && s >= m_peak[c]) begin
            m_peak[c] = s; m_hold[c] = HC; m_pn[c] = 1;
         end else if (en) begin
            if (m_hold[c] > 0) m_hold[c] = m_hold[c] - 1;
            else m_peak[c] = (m_peak[c] > DS) ? m_peak[c] - DS : 0;
         end
      end
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic drive(input logic e, input logic c, input logic [1:0] l,
                        input logic [1:0] r, input logic [15:0] d);
      en = e; clr = c; ld = l; er = r; din = d;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        en, clr;
      logic [1:0]  ld, er;
      logic [15:0] din;
      logic [15:0] e_dout, e_peak;
      logic [1:0]  e_pn, e_err;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic e, input logic c, input logic [1:0] l, input logic [1:0] r,
                      input logic [15:0] d, input logic [15:0] xd, input logic [15:0] xp,
                      input logic [1:0] xn, input logic [1:0] xe);
      vec_t v;
      v.en = e; v.clr = c; v.ld = l; v.er = r; v.din = d;
      v.e_dout = xd; v.e_peak = xp; v.e_pn = xn; v.e_err = xe;
      tbl.push_back(v);
   endtask

   initial begin
      // capture, hold for 4 more cycles, decay to zero
      add(1,0,2'b01,2'b00,16'h0080, 16'hFF80,16'h0080,2'b01,2'b00);
      for (int i = 0; i < 4; i++) add(1,0,2'b00,2'b00,16'h0000, 16'hFF80,16'h0080,2'b00,2'b00);
      for (int k = 7; k >= 0; k--) add(1,0,2'b00,2'b00,16'h0000, 16'hFF80,16'(k*16),2'b00,2'b00);
      add(1,0,2'b00,2'b00,16'h0000, 16'hFF80,16'h0000,2'b00,2'b00);
      // smaller sample does not restart the hold
      add(1,0,2'b01,2'b00,16'h0080, 16'hFF80,16'h0080,2'b01,2'b00);
      add(1,0,2'b00,2'b00,16'h0000, 16'hFF80,16'h0080,2'b00,2'b00);
      add(1,0,2'b01,2'b00,16'h0040, 16'hFF40,16'h0080,2'b00,2'b00);
      add(1,0,2'b00,2'b00,16'h0000, 16'hFF40,16'h0080,2'b00,2'b00);
      add(1,0,2'b00,2'b00,16'h0000, 16'hFF40,16'h0080,2'b00,2'b00);
      add(1,0,2'b00,2'b00,16'h0000, 16'hFF40,16'h0070,2'b00,2'b00);
      // larger and then equal sample restart the hold
      add(1,0,2'b01,2'b00,16'h0080, 16'hFF80,16'h0080,2'b01,2'b00);
      add(1,0,2'b01,2'b00,16'h0080, 16'hFF80,16'h0080,2'b01,2'b00);
      for (int i = 0; i < 4; i++) add(1,0,2'b00,2'b00,16'h0000, 16'hFF80,16'h0080,2'b00,2'b00);
      add(1,0,2'b00,2'b00,16'h0000, 16'hFF80,16'h0070,2'b00,2'b00);
      // rejected load, then clear
      add(1,0,2'b10,2'b10,16'hF000, 16'hFF80,16'h0060,2'b00,2'b10);
      add(1,1,2'b00,2'b00,16'h0000, 16'hFF80,16'h0000,2'b00,2'b00);
      add(1,0,2'b00,2'b00,16'h0000, 16'hFF80,16'h0000,2'b00,2'b00);
      // clear with accept: data loads, peak does not
      add(1,1,2'b01,2'b00,16'h0055, 16'hFF55,16'h0000,2'b00,2'b00);
      add(1,0,2'b00,2'b00,16'h0000, 16'hFF55,16'h0000,2'b00,2'b00);
      // clear wins over a reject
      add(1,1,2'b10,2'b10,16'h3300, 16'hFF55,16'h0000,2'b00,2'b00);
      // both channels at once
      add(1,0,2'b11,2'b00,16'h9020, 16'h9020,16'h9020,2'b11,2'b00);
   end

   // ---------------- main sequence ----------------
   initial begin
      rst = 1'b1;
      drive(0,0,2'b00,2'b00,16'h0000);
      model_reset();
      #2;
      chk("reset_dout",  dout, 16'hFFFF);
      chk("reset_peak",  peak, 16'h0000);
      chk("reset_pnew",  {14'd0, pnew}, 16'h0000);
      chk("reset_err",   {14'd0, errs}, 16'h0000);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // directed table
      foreach (tbl[i]) begin
         drive(tbl[i].en, tbl[i].clr, tbl[i].ld, tbl[i].er, tbl[i].din);
         tick();
         chk($sformatf("tbl%0d_dout", i), dout, tbl[i].e_dout);
         chk($sformatf("tbl%0d_peak", i), peak, tbl[i].e_peak);
         chk($sformatf("tbl%0d_pnew", i), {14'd0, pnew}, {14'd0, tbl[i].e_pn});
         chk($sformatf("tbl%0d_err",  i), {14'd0, errs}, {14'd0, tbl[i].e_err});
      end

      // enable low freezes a running hold, then countdown resumes
      do_reset();
      drive(1,0,2'b01,2'b00,16'h0080);
      tick();
      chk("frz_cap_peak", peak, 16'h0080);
      chk("frz_cap_pnew", {14'd0, pnew}, 16'h0001);
      drive(0,0,2'b01,2'b00,16'h00FF);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("frz%0d_dout", i), dout, 16'hFF80);
         chk($sformatf("frz%0d_peak", i), peak, 16'h0080);
         chk($sformatf("frz%0d_pnew", i), {14'd0, pnew}, 16'h0000);
      end
      drive(1,0,2'b00,2'b00,16'h0000);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("resume%0d_peak", i), peak, 16'h0080);
      end
      drive(1,0,2'b10,2'b10,16'h0000);
      tick();
      chk("resume_decay1", peak, 16'h0070);
      chk("resume_err", {14'd0, errs}, 16'h0002);
      drive(1,0,2'b00,2'b00,16'h0000);
      tick();
      chk("resume_decay2", peak, 16'h0060);

      // asynchronous reset in the middle of decay
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("async_rst_dout", dout, 16'hFFFF);
      chk("async_rst_peak", peak, 16'h0000);
      chk("async_rst_err",  {14'd0, errs}, 16'h0000);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // randomized phase against the model
      for (int n = 0; n < 600; n++) begin
         logic [15:0] xd, xp;
         logic [1:0]  xn, xe;
         en  = ($urandom_range(0, 9) != 0);
         clr = ($urandom_range(0, 49) == 0);
         for (int c = 0; c < CH; c++) begin
            ld[c] = ($urandom_range(0, 3) == 0);
            er[c] = ($urandom_range(0, 7) == 0);
         end
         din = 16'($urandom);
         tick();
         for (int c = 0; c < CH; c++) begin
            xd[c*W +: W] = 8'(m_data[c]);
            xp[c*W +: W] = 8'(m_peak[c]);
            xn[c] = m_pn[c];
            xe[c] = m_err[c];
         end
         chk($sformatf("rnd%0d_dout", n), dout, xd);
         chk($sformatf("rnd%0d_peak", n), peak, xp);
         chk($sformatf("rnd%0d_pnew", n), {14'd0, pnew}, {14'd0, xn});
         chk($sformatf("rnd%0d_err",  n), {14'd0, errs}, {14'd0, xe});
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
